// File: rtl/sc_fetch_pkg.sv
// ============================================================================
// sc_fetch_pkg : shared state encoding and default constants for the fetch
//                sequencer.
// Revision     : 1.0
// ============================================================================
`default_nettype none

package sc_fetch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_REQ   = ST_REQ,
    S_FLUSH = ST_FLUSH,
    S_WRITE = ST_WRITE
  } fetch_state_e;

  localparam int unsigned DEF_PC_STEP  = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/sc_fetch_pc.sv
// ============================================================================
// sc_fetch_pc : program counter with a load port and an increment port;
//               load wins over increment, arithmetic wraps silently.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sc_fetch_pc #(
  parameter int                     ADDRWIDTH = 32,
  parameter logic [ADDRWIDTH-1:0]   RESET_PC  = '0,
  parameter int unsigned            PC_STEP   = 4
) (
  input  logic                  SC_RegGENERAL_CLOCK_50,
  input  logic                  SC_RegGENERAL_Reset_InHigh,
  input  logic                  load_in,
  input  logic [ADDRWIDTH-1:0]  target_in,
  input  logic                  inc_in,
  output logic [ADDRWIDTH-1:0]  pc_out
);

  logic [ADDRWIDTH-1:0] pc_q;
  logic [ADDRWIDTH-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_in) begin
      pc_d = target_in;
    end else if (inc_in) begin
      pc_d = pc_q + ADDRWIDTH'(PC_STEP);
    end
  end

  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_out = pc_q;

endmodule

`default_nettype wire

// File: rtl/sc_fetch_ctrl.sv
// ============================================================================
// sc_fetch_ctrl : instruction-fetch sequencer; req/ack memory handshake,
//                 branch redirect via FLUSH, one-cycle IR write strobe.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sc_fetch_ctrl
  import sc_fetch_pkg::*;
#(
  parameter int                     DATAWIDTH_BUS = 32,
  parameter int                     ADDRWIDTH     = 32,
  parameter logic [ADDRWIDTH-1:0]   RESET_PC      = ADDRWIDTH'(DEF_RESET_PC),
  parameter int unsigned            PC_STEP       = DEF_PC_STEP
) (
  input  logic                      SC_RegGENERAL_CLOCK_50,
  input  logic                      SC_RegGENERAL_Reset_InHigh,
  input  logic                      SC_FETCH_Start_InHigh,
  input  logic                      SC_FETCH_Branch_InHigh,
  input  logic [ADDRWIDTH-1:0]      SC_FETCH_Target_In,
  output logic                      SC_FETCH_MemReq_OutHigh,
  output logic [ADDRWIDTH-1:0]      SC_FETCH_MemAddr_Out,
  input  logic                      SC_FETCH_MemAck_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]  SC_FETCH_MemData_In,
  output logic                      SC_FETCH_IRWrite_OutHigh,
  output logic [DATAWIDTH_BUS-1:0]  SC_FETCH_IRData_Out,
  output logic [ADDRWIDTH-1:0]      SC_FETCH_PC_Out,
  output logic                      SC_FETCH_Busy_OutHigh,
  output logic                      SC_FETCH_Done_OutHigh
);

  fetch_state_e               state_q, state_d;
  logic                       mem_req_q, mem_req_d;
  logic                       ir_write_q, ir_write_d;
  logic                       busy_q, busy_d;
  logic [DATAWIDTH_BUS-1:0]   data_q, data_d;
  logic [ADDRWIDTH-1:0]       pc;

  // Branch always redirects the PC; increment only on the IR write cycle.
  sc_fetch_pc #(
    .ADDRWIDTH (ADDRWIDTH),
    .RESET_PC  (RESET_PC),
    .PC_STEP   (PC_STEP)
  ) u_pc (
    .SC_RegGENERAL_CLOCK_50     (SC_RegGENERAL_CLOCK_50),
    .SC_RegGENERAL_Reset_InHigh (SC_RegGENERAL_Reset_InHigh),
    .load_in                    (SC_FETCH_Branch_InHigh),
    .target_in                  (SC_FETCH_Target_In),
    .inc_in                     (state_q == S_WRITE),
    .pc_out                     (pc)
  );

  always_comb begin
    state_d   = state_q;
    mem_req_d = 1'b0;
    data_d    = data_q;
    case (state_q)
      S_IDLE: begin
        if (SC_FETCH_Start_InHigh) begin
          state_d   = S_REQ;
          mem_req_d = 1'b1;
        end
      end
      S_REQ: begin
        mem_req_d = 1'b1;
        // A REQ cycle with the request low is the gap after a discarded word.
        if (mem_req_q) begin
          if (SC_FETCH_MemAck_InHigh && SC_FETCH_Branch_InHigh) begin
            mem_req_d = 1'b0;
          end else if (SC_FETCH_MemAck_InHigh) begin
            data_d    = SC_FETCH_MemData_In;
            state_d   = S_WRITE;
            mem_req_d = 1'b0;
          end else if (SC_FETCH_Branch_InHigh) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        mem_req_d = 1'b1;
        if (SC_FETCH_MemAck_InHigh) begin
          state_d = S_REQ;
        end
      end
      S_WRITE: begin
        if (SC_FETCH_Start_InHigh) begin
          state_d   = S_REQ;
          mem_req_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ir_write_d = (state_d == S_WRITE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_Reset_InHigh) begin
    if (SC_RegGENERAL_Reset_InHigh) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      ir_write_q <= 1'b0;
      busy_q     <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      ir_write_q <= ir_write_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
    end
  end

  assign SC_FETCH_MemReq_OutHigh  = mem_req_q;
  assign SC_FETCH_MemAddr_Out     = pc;
  assign SC_FETCH_PC_Out          = pc;
  assign SC_FETCH_IRWrite_OutHigh = ir_write_q;
  assign SC_FETCH_Done_OutHigh    = ir_write_q;
  assign SC_FETCH_IRData_Out      = data_q;
  assign SC_FETCH_Busy_OutHigh    = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_sc_fetch_ctrl.sv
// ============================================================================
// tb_sc_fetch_ctrl : directed and randomized bench against a transaction-level
//                    model of the fetch sequencer.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_sc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] target = '0;
  logic        ack = 1'b0;
  logic [31:0] mdata = '0;
  logic        mem_req, ir_write, busy, done;
  logic [31:0] mem_addr, ir_data, pc_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Model view: an active fetch session, an outstanding request that may be
  // stale (redirected), a one-cycle gap after a discarded word, a queued IR write.
  logic [31:0] m_pc;
  logic [31:0] m_word;
  bit          m_active, m_req, m_stale, m_gap, m_wr;

  always #5 clk = ~clk;

  sc_fetch_ctrl dut (
    .SC_RegGENERAL_CLOCK_50     (clk),
    .SC_RegGENERAL_Reset_InHigh (rst),
    .SC_FETCH_Start_InHigh      (start),
    .SC_FETCH_Branch_InHigh     (branch),
    .SC_FETCH_Target_In         (target),
    .SC_FETCH_MemReq_OutHigh    (mem_req),
    .SC_FETCH_MemAddr_Out       (mem_addr),
    .SC_FETCH_MemAck_InHigh     (ack),
    .SC_FETCH_MemData_In        (mdata),
    .SC_FETCH_IRWrite_OutHigh   (ir_write),
    .SC_FETCH_IRData_Out        (ir_data),
    .SC_FETCH_PC_Out            (pc_out),
    .SC_FETCH_Busy_OutHigh      (busy),
    .SC_FETCH_Done_OutHigh      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_word = 32'h0;
    m_active = 0; m_req = 0; m_stale = 0; m_gap = 0; m_wr = 0;
  endtask

  task automatic model_step(input bit s, input bit b, input logic [31:0] t,
                            input bit a, input logic [31:0] d);
    if (m_wr) begin
      m_wr = 0;
      m_pc = b ? t : m_pc + 32'd4;
      m_active = s; m_req = s; m_stale = 0;
    end else if (!m_active) begin
      if (b) m_pc = t;
      if (s) begin m_active = 1; m_req = 1; m_stale = 0; end
    end else if (m_gap) begin
      if (b) m_pc = t;
      m_gap = 0; m_req = 1;
    end else if (!m_stale) begin
      if (a && !b) begin m_word = d; m_wr = 1; m_req = 0; end
      else if (b && !a) begin m_pc = t; m_stale = 1; end
      else if (a && b) begin m_pc = t; m_req = 0; m_gap = 1; end
    end else begin
      if (b) m_pc = t;
      if (a) m_stale = 0;
    end
  endtask

  task automatic compare_all();
    check("mem_req",  {31'b0, mem_req},  {31'b0, m_req});
    check("mem_addr", mem_addr, m_pc);
    check("pc",       pc_out,   m_pc);
    check("ir_write", {31'b0, ir_write}, {31'b0, m_wr});
    check("done",     {31'b0, done},     {31'b0, m_wr});
    check("busy",     {31'b0, busy},     {31'b0, m_active});
    check("ir_data",  ir_data,  m_word);
  endtask

  task automatic step(input bit s, input bit b, input logic [31:0] t,
                      input bit a, input logic [31:0] d);
    start = s; branch = b; target = t; ack = a; mdata = d;
    @(posedge clk);
    model_step(s, b, t, a, d);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 0; branch = 0; ack = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    compare_all();
  endtask

  initial begin
    int wait_cnt;
    bit s, b, a;
    logic [31:0] t, d;
    model_reset();

    do_reset();
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_pc",      pc_out,  32'h0);
    check("rst_ir_data", ir_data, 32'h0);
    check("rst_busy",    {31'b0, busy}, 32'd0);

    // Sequential fetches with a one-cycle memory wait.
    step(1, 0, 0, 0, 0);
    check("f1_req",  {31'b0, mem_req}, 32'd1);
    check("f1_addr", mem_addr, 32'h0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'hA000_0001);
    check("f1_irw",  {31'b0, ir_write}, 32'd1);
    check("f1_word", ir_data, 32'hA000_0001);
    step(1, 0, 0, 0, 0);
    check("f2_addr", mem_addr, 32'h4);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hA000_0002);
    check("f2_word", ir_data, 32'hA000_0002);
    step(0, 0, 0, 0, 0);
    check("f2_pc",   pc_out, 32'h8);
    check("f2_idle", {31'b0, busy}, 32'd0);

    // Ack in IDLE is ignored.
    step(0, 0, 0, 1, 32'h1234_5678);
    check("idle_ack_irw",  {31'b0, ir_write}, 32'd0);
    check("idle_ack_busy", {31'b0, busy}, 32'd0);
    check("idle_ack_data", ir_data, 32'hA000_0002);

    // Branch during REQ: flush the outstanding word.
    step(1, 0, 0, 0, 0);
    check("br_addr0", mem_addr, 32'h8);
    step(0, 1, 32'h100, 0, 0);
    check("br_flush_req", {31'b0, mem_req}, 32'd1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("br_flush_hold", {31'b0, mem_req}, 32'd1);
    step(0, 0, 0, 1, 32'h0000_DEAD);
    check("br_no_irw", {31'b0, ir_write}, 32'd0);
    check("br_addr1",  mem_addr, 32'h100);
    check("br_req1",   {31'b0, mem_req}, 32'd1);
    step(1, 0, 0, 1, 32'h11);
    check("br_word", ir_data, 32'h11);

    // Branch coincident with Ack: one-cycle request gap.
    step(1, 0, 0, 0, 0);
    check("ba_addr0", mem_addr, 32'h104);
    step(1, 1, 32'h200, 1, 32'hBAD);
    check("ba_gap",   {31'b0, mem_req}, 32'd0);
    check("ba_noirw", {31'b0, ir_write}, 32'd0);
    step(1, 0, 0, 0, 0);
    check("ba_req",   {31'b0, mem_req}, 32'd1);
    check("ba_addr",  mem_addr, 32'h200);
    step(1, 0, 0, 1, 32'h22);

    // PC wrap.
    step(1, 1, 32'hFFFF_FFFC, 0, 0);
    check("wr_addr", mem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 1, 32'h33);
    check("wr_irw", {31'b0, ir_write}, 32'd1);
    step(0, 0, 0, 0, 0);
    check("wr_pc", pc_out, 32'h0);

    // Asynchronous reset in the middle of a request.
    step(1, 0, 32'h0, 0, 0);
    step(1, 1, 32'h40, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("ar_req", {31'b0, mem_req}, 32'd0);
    check("ar_pc",  pc_out, 32'h0);
    model_reset();
    start = 0; branch = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    step(0, 0, 0, 1, 32'h44);
    check("ar_late_ack", {31'b0, ir_write}, 32'd0);

    // Randomized traffic with a variable-latency responder.
    wait_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 9) < 8);
      b = ($urandom_range(0, 9) == 0);
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
      d = $urandom;
      if (m_req) begin
        if (wait_cnt == 0) begin
          a = 1;
          wait_cnt = $urandom_range(0, 3);
        end else begin
          a = 0;
          wait_cnt--;
        end
      end else begin
        a = ($urandom_range(0, 7) == 0);
      end
      step(s, b, t, a, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
